word_serializer: RTL and testbench
==================================

WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 10: bits per word, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = word bit WIDTH-1 emitted first, 0 = bit 0 emitted first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  shift strobe; one bit emitted per en-high cycle while a word is in flight.
REQ-006 load_valid  input  1  upstream has a word on load_data.
REQ-007 load_data  input  WIDTH  parallel word to serialize.
REQ-008 load_ready  output  1  combinational; word accepted on a cycle with load_valid && load_ready.
REQ-009 out  output  1  registered serial data bit.
REQ-010 out_valid  output  1  registered; one-cycle pulse marking a newly emitted bit on out.
REQ-011 frame_start  output  1  registered; high with out_valid for the first bit of each word.
REQ-012 busy  output  1  registered; high while state is SHIFT.

Function
REQ-013 FSM states: IDLE, SHIFT; no other states.
REQ-014 load_ready SHALL be 1 in IDLE, and in SHIFT only when bit count is 0 and en=1, otherwise 0.
REQ-015 Accept in IDLE: capture load_data into the WIDTH-bit shift register, set count to WIDTH-1, arm first-bit flag, go to SHIFT; no bit is emitted in the accept cycle.
REQ-016 In SHIFT with en=1: out <= selected end bit (MSB if MSB_FIRST, else LSB); shift register shifts toward that end, zero-filled; out_valid <= 1; frame_start <= first-bit flag; flag cleared.
REQ-017 In SHIFT with en=1 and count>0: count decrements by 1, stay in SHIFT.
REQ-018 In SHIFT with en=1 and count=0 (last bit): reload per REQ-015 and stay in SHIFT if load_valid=1, else go to IDLE; back-to-back words SHALL stream with no idle strobe between them.
REQ-019 In SHIFT with en=0: out, shift register, count unchanged; out_valid and frame_start <= 0.
REQ-020 In IDLE: out <= 0, out_valid <= 0, frame_start <= 0 regardless of en; load_data ignored unless load_valid=1.
REQ-021 Exactly WIDTH out_valid pulses per accepted word; latency from accept to first bit = one clock plus wait for the next en=1 cycle.
REQ-022 load_data and load_valid changes SHALL have no effect while load_ready=0.

Reset
REQ-023 rst=1 at a rising edge: state IDLE, out=0, out_valid=0, frame_start=0, busy=0, count=0, shift register=0, first-bit flag=0; rst has priority over en and load_valid.
REQ-024 Reset mid-word SHALL discard the remaining bits; load_ready=1 in the first cycle after rst deasserts.

Structure
REQ-025 Shared package ser_pkg SHALL hold the state enumeration type and the default word width constant (10); the count width is derived as clog2(WIDTH).
REQ-026 Single module; counter, FSM and shift register inline, no sub-module.

Verification
REQ-027 WIDTH=10, MSB_FIRST=1, en held 1, load 10'b1011001110: out = 1,0,1,1,0,0,1,1,1,0 on 10 consecutive out_valid cycles; frame_start only on the first; busy high 10 cycles, then low.
REQ-028 Same word, en high 1 cycle in 3: identical bit sequence; out holds between pulses; exactly 10 out_valid pulses.
REQ-029 load_valid held high with 10'h3FF then 10'h000, en=1: 20 contiguous out_valid pulses (ten 1s then ten 0s); load_ready high during the 10th bit cycle; frame_start on bits 1 and 11; busy never drops.
REQ-030 rst asserted for 1 cycle after 4 bits of 10'h2AA: next cycle out=0, out_valid=0, busy=0, load_ready=1; reloaded word emits all 10 bits from the start.
REQ-031 MSB_FIRST=0, load 10'b0000000011: out = 1,1,0,0,0,0,0,0,0,0.
REQ-032 Loopback: out/out_valid drive a 10-bit serial-in deserializer model (shift on out_valid); after 10 pulses the deserializer holds the loaded word for 100 random words.

Source files
------------

// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ser_pkg
// Brief    : Shared types and constants for the word serializer.
// Revision : 1.0
// ============================================================================
package ser_pkg;

  localparam int c_def_width = 10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : word_serializer
// Brief    : Parallel-to-serial converter with strobed shifting and framing.
// Revision : 1.0
// ============================================================================
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = c_def_width,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int c_cnt_w = $clog2(WIDTH);

  ser_state_t         r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [c_cnt_w-1:0] r_count;
  logic               r_first;
  logic               r_out;
  logic               r_out_valid;
  logic               r_frame_start;
  logic               r_busy;

  logic               w_end_bit;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_last;

  assign w_last     = (r_count == '0);
  assign load_ready = (r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_last && en);

  always_comb begin
    w_end_bit = 1'b0;
    w_shifted = '0;
    if (MSB_FIRST) begin
      w_end_bit = r_shreg[WIDTH-1];
      w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      w_end_bit = r_shreg[0];
      w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shreg       <= '0;
      r_count       <= '0;
      r_first       <= 1'b0;
      r_out         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_out         <= 1'b0;
          r_out_valid   <= 1'b0;
          r_frame_start <= 1'b0;
          if (load_valid) begin
            r_shreg <= load_data;
            r_count <= c_cnt_w'(WIDTH - 1);
            r_first <= 1'b1;
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            r_out         <= w_end_bit;
            r_shreg       <= w_shifted;
            r_out_valid   <= 1'b1;
            r_frame_start <= r_first;
            r_first       <= 1'b0;
            if (!w_last) begin
              r_count <= r_count - 1'b1;
            end else if (load_valid) begin
              // Reload overrides the shift so the next word streams without a gap
              r_shreg <= load_data;
              r_count <= c_cnt_w'(WIDTH - 1);
              r_first <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_out_valid   <= 1'b0;
            r_frame_start <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign frame_start = r_frame_start;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_serializer
// Brief    : Directed self-checking bench for word_serializer (both bit orders).
// Revision : 1.0
// ============================================================================
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       lv0 = 1'b0, lv1 = 1'b0;
  logic [9:0] ld0 = '0, ld1 = '0;
  logic       lr0, out0, ov0, fs0, busy0;
  logic       lr1, out1, ov1, fs1, busy1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(10), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst(rst), .en(en), .load_valid(lv0), .load_data(ld0),
    .load_ready(lr0), .out(out0), .out_valid(ov0), .frame_start(fs0), .busy(busy0)
  );

  word_serializer #(.WIDTH(10), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst(rst), .en(en), .load_valid(lv1), .load_data(ld1),
    .load_ready(lr1), .out(out1), .out_valid(ov1), .frame_start(fs1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] seq;
    logic [9:0] des;
    logic [9:0] w;
    logic       prev;
    int         pulses;
    int         cyc;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check("rst_out", out0, 0);
    check("rst_ov", ov0, 0);
    check("rst_fs", fs0, 0);
    check("rst_busy", busy0, 0);
    check("rst_lr", lr0, 1);

    // Continuous strobe, MSB first
    seq = 10'b1011001110;
    en = 1'b1; lv0 = 1'b1; ld0 = 10'b1011001110;
    tick();
    lv0 = 1'b0; ld0 = '0;
    check("acc_busy", busy0, 1);
    check("acc_ov", ov0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("c_ov", ov0, 1);
      check("c_out", out0, seq[9-i]);
      check("c_fs", fs0, (i == 0));
      check("c_busy", busy0, (i < 9));
    end
    tick();
    check("c_end_ov", ov0, 0);
    check("c_end_busy", busy0, 0);
    check("c_end_out", out0, 0);

    // Strobe one cycle in three
    lv0 = 1'b1; ld0 = 10'b1011001110;
    tick();
    lv0 = 1'b0;
    pulses = 0; prev = 1'b0;
    for (int c = 0; c < 45; c++) begin
      en = (c % 3 == 2);
      tick();
      if (ov0) begin
        if (pulses < 10) check("s_out", out0, seq[9-pulses]);
        check("s_fs", fs0, (pulses == 0));
        prev = out0;
        pulses++;
      end else if (pulses > 0 && pulses < 10) begin
        check("s_hold", out0, prev);
      end
    end
    check("s_pulses", pulses, 10);

    // Back-to-back words with load_valid held
    en = 1'b1; lv0 = 1'b1; ld0 = 10'h3FF;
    tick();
    ld0 = 10'h000;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) check("b_lr_mid", lr0, 0);
      if (i == 9) check("b_lr_last", lr0, 1);
      tick();
      if (i == 9) lv0 = 1'b0;
      check("b_ov", ov0, 1);
      check("b_out", out0, (i < 10));
      check("b_fs", fs0, (i == 0 || i == 10));
      check("b_busy", busy0, (i < 19));
    end
    tick();

    // Reset in mid-word
    seq = 10'b1010101010;
    lv0 = 1'b1; ld0 = 10'h2AA;
    tick();
    lv0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("r_pre_out", out0, seq[9-i]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_out", out0, 0);
    check("r_ov", ov0, 0);
    check("r_busy", busy0, 0);
    check("r_lr", lr0, 1);
    lv0 = 1'b1;
    tick();
    lv0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("r_ov2", ov0, 1);
      check("r_out2", out0, seq[9-i]);
      check("r_fs2", fs0, (i == 0));
    end
    tick();

    // LSB first
    seq = 10'b1100000000;
    lv1 = 1'b1; ld1 = 10'b0000000011;
    tick();
    lv1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("l_ov", ov1, 1);
      check("l_out", out1, seq[9-i]);
      check("l_fs", fs1, (i == 0));
    end
    tick();
    check("l_idle", busy1, 0);

    // Loopback through a serial-in deserializer model
    for (int k = 0; k < 100; k++) begin
      w = 10'($urandom);
      en = 1'b1; lv0 = 1'b1; ld0 = w;
      tick();
      lv0 = 1'b0; ld0 = ~w;
      pulses = 0; des = '0; cyc = 0;
      while (pulses < 10 && cyc < 200) begin
        en = ($urandom_range(0, 3) != 0);
        tick();
        if (ov0) begin
          des = {des[8:0], out0};
          pulses++;
        end
        cyc++;
      end
      check("lb_pulses", pulses, 10);
      check("lb_word", des, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
